// File: rtl/exception_ctrl.sv
// MEM-stage exception/interrupt arbiter: picks the highest-priority event,
// emits one-cycle CP0 update strobes and holds a flush/redirect for FLUSH_CYCLES.
module exception_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_slot_i,
  input  logic [31:0] badvaddr_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        cp0_exc_we_o,
  output logic [31:0] cp0_epc_o,
  output logic [4:0]  cp0_exccode_o,
  output logic        cp0_bd_o,
  output logic        cp0_badvaddr_we_o,
  output logic [31:0] cp0_badvaddr_o,
  output logic        cp0_exl_clr_o,
  output logic        busy_o
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FLUSH = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  logic        state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        exc_we_q, exc_we_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic        bva_we_q, bva_we_d;
  logic [31:0] bva_q, bva_d;
  logic        exl_clr_q, exl_clr_d;

  logic        irq_pending;
  logic        accept;
  logic        ev_eret;
  logic [4:0]  ev_code;
  logic        ev_bva_we;
  logic [31:0] ev_bva;

  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  assign irq_pending = exc_valid_i && status_i[0] && !status_i[1]
                       && (|(cause_i[15:8] & status_i[15:8]));
  assign accept = exc_valid_i && !stall_i && (irq_pending || (|exc_flags_i));

  // Priority encoder; ERET is only reached when nothing else is pending.
  always_comb begin
    ev_eret   = 1'b0;
    ev_code   = 5'd0;
    ev_bva_we = 1'b0;
    ev_bva    = badvaddr_i;
    if (irq_pending) begin
      ev_code = 5'd0;
    end else if (exc_flags_i[0]) begin
      ev_code   = 5'd4;
      ev_bva_we = 1'b1;
      ev_bva    = pc_i;
    end else if (exc_flags_i[1]) begin
      ev_code = 5'd10;
    end else if (exc_flags_i[2]) begin
      ev_code = 5'd12;
    end else if (exc_flags_i[3]) begin
      ev_code = 5'd8;
    end else if (exc_flags_i[4]) begin
      ev_code = 5'd9;
    end else if (exc_flags_i[5]) begin
      ev_code   = 5'd4;
      ev_bva_we = 1'b1;
    end else if (exc_flags_i[6]) begin
      ev_code   = 5'd5;
      ev_bva_we = 1'b1;
    end else begin
      ev_eret = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    new_pc_d  = new_pc_q;
    exc_we_d  = 1'b0;
    epc_d     = epc_q;
    exccode_d = exccode_q;
    bd_d      = bd_q;
    bva_we_d  = 1'b0;
    bva_d     = bva_q;
    exl_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_FLUSH;
          cnt_d     = CNT_INIT;
          flush_d   = 1'b1;
          new_pc_d  = ev_eret ? epc_i : HANDLER_ADDR;
          exc_we_d  = !ev_eret;
          exl_clr_d = ev_eret;
          bva_we_d  = ev_bva_we;
          if (!ev_eret) begin
            epc_d     = in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
            exccode_d = ev_code;
            bd_d      = in_delay_slot_i;
          end
          if (ev_bva_we) bva_d = ev_bva;
        end
      end
      default: begin
        // The last FLUSH cycle is the one entered with the counter at 0.
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      flush_q   <= 1'b0;
      new_pc_q  <= 32'd0;
      exc_we_q  <= 1'b0;
      epc_q     <= 32'd0;
      exccode_q <= 5'd0;
      bd_q      <= 1'b0;
      bva_we_q  <= 1'b0;
      bva_q     <= 32'd0;
      exl_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      new_pc_q  <= new_pc_d;
      exc_we_q  <= exc_we_d;
      epc_q     <= epc_d;
      exccode_q <= exccode_d;
      bd_q      <= bd_d;
      bva_we_q  <= bva_we_d;
      bva_q     <= bva_d;
      exl_clr_q <= exl_clr_d;
    end
  end

  assign flush_o           = flush_q;
  assign new_pc_o          = new_pc_q;
  assign cp0_exc_we_o      = exc_we_q;
  assign cp0_epc_o         = epc_q;
  assign cp0_exccode_o     = exccode_q;
  assign cp0_bd_o          = bd_q;
  assign cp0_badvaddr_we_o = bva_we_q;
  assign cp0_badvaddr_o    = bva_q;
  assign cp0_exl_clr_o     = exl_clr_q;
  assign busy_o            = state_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_exception_ctrl;

  localparam int FC = 2;
  localparam logic [31:0] HANDLER = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        in_delay_slot_i = 1'b0;
  logic [31:0] badvaddr_i = '0;
  logic [7:0]  exc_flags_i = '0;
  logic [31:0] status_i = '0;
  logic [31:0] cause_i = '0;
  logic [31:0] epc_i = '0;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        cp0_exc_we_o;
  logic [31:0] cp0_epc_o;
  logic [4:0]  cp0_exccode_o;
  logic        cp0_bd_o;
  logic        cp0_badvaddr_we_o;
  logic [31:0] cp0_badvaddr_o;
  logic        cp0_exl_clr_o;
  logic        busy_o;

  exception_ctrl #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid_i(exc_valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .in_delay_slot_i(in_delay_slot_i), .badvaddr_i(badvaddr_i),
    .exc_flags_i(exc_flags_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .cp0_exc_we_o(cp0_exc_we_o), .cp0_epc_o(cp0_epc_o),
    .cp0_exccode_o(cp0_exccode_o), .cp0_bd_o(cp0_bd_o),
    .cp0_badvaddr_we_o(cp0_badvaddr_we_o), .cp0_badvaddr_o(cp0_badvaddr_o),
    .cp0_exl_clr_o(cp0_exl_clr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        acc;
    logic        eret;
    logic [4:0]  code;
    logic        bva_we;
    logic [31:0] bva;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] newpc;
  } ev_t;

  function automatic ev_t calc(input logic v, input logic st, input logic [31:0] pc,
                               input logic ds, input logic [31:0] bva,
                               input logic [7:0] f, input logic [31:0] status,
                               input logic [31:0] cause, input logic [31:0] epc);
    ev_t e;
    logic irq;
    logic found;
    logic [4:0] codes [7];
    codes = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    irq = v && status[0] && !status[1] && ((cause[15:8] & status[15:8]) != 8'd0);
    e = '0;
    e.acc = v && !st && (irq || (f != 8'd0));
    if (!irq) begin
      found = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (!found && f[i]) begin
          found  = 1'b1;
          e.code = codes[i];
          if (i == 0) begin e.bva_we = 1'b1; e.bva = pc; end
          if (i >= 5) begin e.bva_we = 1'b1; e.bva = bva; end
        end
      end
      e.eret = !found;
    end
    e.epc   = ds ? pc - 32'd4 : pc;
    e.bd    = ds;
    e.newpc = e.eret ? epc : HANDLER;
    return e;
  endfunction

  ev_t ev;
  always_comb ev = calc(exc_valid_i, stall_i, pc_i, in_delay_slot_i, badvaddr_i,
                        exc_flags_i, status_i, cause_i, epc_i);

  int          m_rem;
  logic        m_exc_we, m_bva_we, m_exl_clr, m_bd;
  logic [31:0] m_pc, m_epc, m_bva;
  logic [4:0]  m_code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_exc_we <= 1'b0; m_bva_we <= 1'b0; m_exl_clr <= 1'b0;
      m_pc <= '0; m_epc <= '0; m_bva <= '0; m_code <= '0; m_bd <= 1'b0;
    end else begin
      m_exc_we <= 1'b0; m_bva_we <= 1'b0; m_exl_clr <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end else if (ev.acc) begin
        m_rem     <= FC;
        m_exc_we  <= !ev.eret;
        m_exl_clr <= ev.eret;
        m_bva_we  <= ev.bva_we;
        m_pc      <= ev.newpc;
        m_epc     <= ev.epc;
        m_code    <= ev.code;
        m_bd      <= ev.bd;
        m_bva     <= ev.bva;
        $display("event t=%0t eret=%0b code=%0d epc=%h newpc=%h bva_we=%0b",
                 $time, ev.eret, ev.code, ev.epc, ev.newpc, ev.bva_we);
      end
    end
  end

  always @(negedge clk) begin
    chk("flush", {31'b0, flush_o}, {31'b0, m_rem > 0});
    chk("busy", {31'b0, busy_o}, {31'b0, m_rem > 0});
    chk("exc_we", {31'b0, cp0_exc_we_o}, {31'b0, m_exc_we});
    chk("bva_we", {31'b0, cp0_badvaddr_we_o}, {31'b0, m_bva_we});
    chk("exl_clr", {31'b0, cp0_exl_clr_o}, {31'b0, m_exl_clr});
    if (m_rem > 0) chk("new_pc", new_pc_o, m_pc);
    if (m_exc_we) begin
      chk("epc", cp0_epc_o, m_epc);
      chk("exccode", {27'b0, cp0_exccode_o}, {27'b0, m_code});
      chk("bd", {31'b0, cp0_bd_o}, {31'b0, m_bd});
    end
    if (m_bva_we) chk("badvaddr", cp0_badvaddr_o, m_bva);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    exc_valid_i = 1'b0; stall_i = 1'b0; pc_i = '0; in_delay_slot_i = 1'b0;
    badvaddr_i = '0; exc_flags_i = '0; status_i = '0; cause_i = '0; epc_i = '0;
  endtask

  task automatic ev_in(input logic [31:0] pc, input logic ds, input logic [7:0] f,
                       input logic [31:0] status, input logic [31:0] cause);
    exc_valid_i = 1'b1; stall_i = 1'b0; pc_i = pc; in_delay_slot_i = ds;
    exc_flags_i = f; status_i = status; cause_i = cause;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flush"}, {31'b0, flush_o}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_new_pc"}, new_pc_o, 32'd0);
    chk({tag, "_epc"}, cp0_epc_o, 32'd0);
    chk({tag, "_exccode"}, {27'b0, cp0_exccode_o}, 32'd0);
    chk({tag, "_bva"}, cp0_badvaddr_o, 32'd0);
    chk({tag, "_strobes"}, {29'b0, cp0_exc_we_o, cp0_badvaddr_we_o, cp0_exl_clr_o}, 32'd0);
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Syscall
    ev_in(32'h80001000, 1'b0, 8'h08, 32'h0, 32'h0);
    tick();
    $display("directed: syscall");
    chk("sys_exc_we", {31'b0, cp0_exc_we_o}, 32'd1);
    chk("sys_epc", cp0_epc_o, 32'h80001000);
    chk("sys_code", {27'b0, cp0_exccode_o}, 32'd8);
    chk("sys_bd", {31'b0, cp0_bd_o}, 32'd0);
    chk("sys_newpc", new_pc_o, 32'hBFC00380);
    chk("sys_flush1", {31'b0, flush_o}, 32'd1);
    clear_in();
    tick();
    chk("sys_flush2", {31'b0, flush_o}, 32'd1);
    chk("sys_strobe_once", {31'b0, cp0_exc_we_o}, 32'd0);
    tick();
    chk("sys_flush_end", {31'b0, flush_o}, 32'd0);

    // Delay slot + RI beats Ov
    ev_in(32'h80000104, 1'b1, 8'h06, 32'h0, 32'h0);
    tick();
    $display("directed: delay slot RI+Ov");
    chk("ds_code", {27'b0, cp0_exccode_o}, 32'd10);
    chk("ds_epc", cp0_epc_o, 32'h80000100);
    chk("ds_bd", {31'b0, cp0_bd_o}, 32'd1);
    clear_in();
    repeat (FC) tick();

    // Interrupt beats syscall, then masked by EXL
    ev_in(32'h80000200, 1'b0, 8'h08, 32'h00000401, 32'h00000400);
    tick();
    $display("directed: interrupt");
    chk("irq_code", {27'b0, cp0_exccode_o}, 32'd0);
    chk("irq_exc_we", {31'b0, cp0_exc_we_o}, 32'd1);
    clear_in();
    repeat (FC) tick();
    ev_in(32'h80000200, 1'b0, 8'h08, 32'h00000403, 32'h00000400);
    tick();
    $display("directed: interrupt masked by EXL");
    chk("exl_code", {27'b0, cp0_exccode_o}, 32'd8);
    clear_in();
    repeat (FC) tick();

    // Store AdES, with new flags held during FLUSH
    ev_in(32'h80000300, 1'b0, 8'h40, 32'h0, 32'h0);
    badvaddr_i = 32'h00000003;
    tick();
    $display("directed: store AdES");
    chk("ades_bva_we", {31'b0, cp0_badvaddr_we_o}, 32'd1);
    chk("ades_bva", cp0_badvaddr_o, 32'h00000003);
    chk("ades_code", {27'b0, cp0_exccode_o}, 32'd5);
    exc_flags_i = 8'h08;
    repeat (FC) tick();
    clear_in();
    tick();
    chk("ignored_flush", {31'b0, flush_o}, 32'd0);
    chk("ignored_exc_we", {31'b0, cp0_exc_we_o}, 32'd0);

    // ERET
    ev_in(32'h80000400, 1'b0, 8'h80, 32'h0, 32'h0);
    epc_i = 32'h80002000;
    tick();
    $display("directed: eret");
    chk("eret_clr", {31'b0, cp0_exl_clr_o}, 32'd1);
    chk("eret_newpc", new_pc_o, 32'h80002000);
    chk("eret_no_exc", {31'b0, cp0_exc_we_o}, 32'd0);
    chk("eret_no_bva", {31'b0, cp0_badvaddr_we_o}, 32'd0);
    clear_in();
    tick();
    chk("eret_clr_once", {31'b0, cp0_exl_clr_o}, 32'd0);
    chk("eret_newpc_hold", new_pc_o, 32'h80002000);
    tick();

    // Stall blocks acceptance
    ev_in(32'h80000500, 1'b0, 8'h08, 32'h0, 32'h0);
    stall_i = 1'b1;
    tick();
    $display("directed: stall");
    chk("stall_flush", {31'b0, flush_o}, 32'd0);
    chk("stall_exc_we", {31'b0, cp0_exc_we_o}, 32'd0);
    clear_in();
    tick();

    // Reset in the middle of FLUSH
    ev_in(32'h80000600, 1'b0, 8'h10, 32'h0, 32'h0);
    tick();
    $display("directed: reset during flush");
    chk("brk_code", {27'b0, cp0_exccode_o}, 32'd9);
    clear_in();
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      exc_valid_i     = ($urandom_range(0, 9) < 8);
      stall_i         = ($urandom_range(0, 4) == 0);
      pc_i            = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      in_delay_slot_i = $urandom_range(0, 1) == 1;
      badvaddr_i      = $urandom;
      epc_i           = $urandom;
      case ($urandom_range(0, 3))
        0: exc_flags_i = 8'h00;
        1: exc_flags_i = 8'(1 << $urandom_range(0, 7));
        2: exc_flags_i = 8'($urandom);
        default: exc_flags_i = 8'h80;
      endcase
      status_i = $urandom;
      cause_i  = $urandom & 32'hFFFF_FFF0;
      if ($urandom_range(0, 2) == 0) cause_i[15:8] = 8'h00;
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    clear_in();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
